start_fifo_srl_ctrl: RTL and testbench

// Sequencing controller for the SRL shift-register storage behind the start-token
// and stream FIFOs between Linear_Layer stages and the PE_i4xi4 array. Converts
// if_write/if_read handshakes into SRL shift-enable and read-address control.

---
 rtl/start_fifo_srl_ctrl_if.sv | 26 ++
 rtl/start_fifo_srl_ctrl.sv | 81 ++++++++
 tb/tb_start_fifo_srl_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/start_fifo_srl_ctrl_if.sv
// Handshake bundle of the SRL-backed show-ahead FIFO: producer write side and
// consumer read side.
interface start_fifo_srl_ctrl_if #(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 1
);
   logic                  if_write_ce;
   logic                  if_write;
   logic [DATA_WIDTH-1:0] if_din;
   logic                  if_full_n;
   logic                  if_read_ce;
   logic                  if_read;
   logic [DATA_WIDTH-1:0] if_dout;
   logic                  if_empty_n;
   logic [ADDR_WIDTH:0]   if_num_data_valid;

   modport master (
      output if_write_ce, if_write, if_din, if_read_ce, if_read,
      input  if_full_n, if_dout, if_empty_n, if_num_data_valid
   );

   modport slave (
      input  if_write_ce, if_write, if_din, if_read_ce, if_read,
      output if_full_n, if_dout, if_empty_n, if_num_data_valid
   );
endinterface

// File: rtl/start_fifo_srl_ctrl.sv
// SRL sequencing controller with one show-ahead output register in front of the
// shift register; capacity DEPTH+1, write-to-read latency one cycle.
module start_fifo_srl_ctrl #(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 1,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   start_fifo_srl_ctrl_if.slave  fifo,
   output logic                  srl_we,
   output logic [ADDR_WIDTH-1:0] srl_addr,
   output logic [DATA_WIDTH-1:0] srl_din,
   input  logic [DATA_WIDTH-1:0] srl_dout
);
   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

   typedef enum logic [1:0] {EMPTY, HEAD, FILL, FULL} state_t;

   logic                  out_valid, out_valid_nx;
   logic [CW-1:0]         cnt, cnt_nx;
   logic [DATA_WIDTH-1:0] out_reg, out_nx;
   state_t                state;
   logic                  push, pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         cnt       <= '0;
         out_reg   <= '0;
      end else begin
         out_valid <= out_valid_nx;
         cnt       <= cnt_nx;
         out_reg   <= out_nx;
      end
   end

   assign push = fifo.if_write & fifo.if_write_ce & fifo.if_full_n;
   assign pop  = fifo.if_read & fifo.if_read_ce & out_valid;

   always_comb begin
      state        = EMPTY;
      out_valid_nx = out_valid;
      cnt_nx       = cnt;
      out_nx       = out_reg;
      srl_we       = 1'b0;
      if (out_valid)
         state = (cnt == '0) ? HEAD : (cnt == CNT_MAX) ? FULL : FILL;
      case (state)
         EMPTY: if (push) begin
            out_valid_nx = 1'b1;
            out_nx       = fifo.if_din;
         end
         // Only the output register is occupied: a simultaneous push/pop
         // bypasses the SRL and lands straight in the output register.
         HEAD: begin
            if (pop && push)
               out_nx = fifo.if_din;
            else if (pop)
               out_valid_nx = 1'b0;
            else if (push) begin
               srl_we = 1'b1;
               cnt_nx = CW'(1);
            end
         end
         default: begin
            if (pop) out_nx = srl_dout;
            srl_we = push;
            cnt_nx = cnt + CW'(push) - CW'(pop);
         end
      endcase
   end

   assign srl_din                = fifo.if_din;
   assign srl_addr               = (cnt != '0) ? ADDR_WIDTH'(cnt - CW'(1)) : '0;
   assign fifo.if_full_n         = (cnt != CNT_MAX);
   assign fifo.if_empty_n        = out_valid;
   assign fifo.if_dout           = out_reg;
   assign fifo.if_num_data_valid = cnt + CW'(out_valid);
endmodule

// File: tb/tb_start_fifo_srl_ctrl.sv
// Directed and random checks of the SRL FIFO controller at DEPTH 2, 1 and 7,
// each against a queue-based FIFO model, with a shift-register SRL in the bench.
module tb_start_fifo_srl_ctrl;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic wr = 1'b0, wce = 1'b0, rd = 1'b0, rce = 1'b0;
   logic [DW-1:0] din = '0;
   bit   chk_en = 1'b0;
   int   vectors = 0;
   int   errors = 0;

   // DEPTH=2 instance observed by the directed section
   logic          full_n0, empty_n0, we0;
   logic [DW-1:0] dout0;
   logic [1:0]    num0;
   logic [0:0]    addr0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   genvar g;
   for (g = 0; g < 3; g++) begin : gd
      localparam int D  = (g == 0) ? 2 : (g == 1) ? 1 : 7;
      localparam int AW = (g == 2) ? 3 : 1;

      start_fifo_srl_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) f ();
      logic          srl_we;
      logic [AW-1:0] srl_addr;
      logic [DW-1:0] srl_din, srl_dout;
      logic [DW-1:0] mem [D];
      logic [DW-1:0] q [$];

      assign f.if_write_ce = wce;
      assign f.if_write    = wr;
      assign f.if_din      = din;
      assign f.if_read_ce  = rce;
      assign f.if_read     = rd;

      start_fifo_srl_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
         .clk      (clk),
         .reset    (rst),
         .fifo     (f.slave),
         .srl_we   (srl_we),
         .srl_addr (srl_addr),
         .srl_din  (srl_din),
         .srl_dout (srl_dout)
      );

      // Behavioural SRL primitive: shift in at 0, asynchronous read
      always @(posedge clk) begin
         if (srl_we) begin
            mem[0] <= srl_din;
            for (int i = 1; i < D; i++) mem[i] <= mem[i-1];
         end
      end
      assign srl_dout = (int'(srl_addr) < D) ? mem[srl_addr] : '0;

      // Reference FIFO: capacity D+1, pushes refused when full before the edge
      always @(posedge clk) begin
         int  sz;
         bit  p_ok, r_ok;
         sz   = q.size();
         p_ok = wr && wce && (sz != D + 1);
         r_ok = rd && rce && (sz != 0);
         if (rst) q.delete();
         else begin
            if (r_ok) void'(q.pop_front());
            if (p_ok) q.push_back(din);
         end
      end

      always @(negedge clk) begin
         int  sz;
         bit  p_ok, r_ok;
         if (chk_en) begin
            sz   = q.size();
            p_ok = wr && wce && (sz != D + 1);
            r_ok = rd && rce && (sz != 0);
            chk($sformatf("d%0d num", D), int'(f.if_num_data_valid), sz);
            chk($sformatf("d%0d empty_n", D), int'(f.if_empty_n), int'(sz != 0));
            chk($sformatf("d%0d full_n", D), int'(f.if_full_n), int'(sz != D + 1));
            if (sz != 0) chk($sformatf("d%0d dout", D), int'(f.if_dout), int'(q[0]));
            chk($sformatf("d%0d srl_we", D), int'(srl_we),
                int'(p_ok && !(sz == 0 || (sz == 1 && r_ok))));
            chk($sformatf("d%0d srl_addr", D), int'(srl_addr), (sz >= 2) ? sz - 2 : 0);
         end
      end

      if (g == 0) begin : exp0
         assign full_n0  = f.if_full_n;
         assign empty_n0 = f.if_empty_n;
         assign dout0    = f.if_dout;
         assign num0     = f.if_num_data_valid;
         assign we0      = srl_we;
         assign addr0    = srl_addr;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] v);
      wr = 1'b1; din = v;
      tick();
      wr = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] v;
      wce = 1'b1; rce = 1'b1;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk_en = 1'b1;

      // idle after reset
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle full_n", int'(full_n0), 1);
         chk("idle empty_n", int'(empty_n0), 0);
         chk("idle num", int'(num0), 0);
         chk("idle dout", int'(dout0), 0);
         chk("idle srl_we", int'(we0), 0);
      end

      // first write bypasses the SRL
      wr = 1'b1; din = 8'h01; #1;
      chk("bypass srl_we", int'(we0), 0);
      tick(); wr = 1'b0;
      chk("bypass empty_n", int'(empty_n0), 1);
      chk("bypass dout", int'(dout0), 1);
      rd = 1'b1; tick(); rd = 1'b0;
      chk("pop empty_n", int'(empty_n0), 0);

      // fill 1,0,1 then a refused 4th write, then drain in order
      push(8'h01); chk("fill num1", int'(num0), 1);
      push(8'h00); chk("fill num2", int'(num0), 2);
      chk("fill addr", int'(addr0), 0);
      push(8'h01); chk("fill num3", int'(num0), 3);
      chk("fill full_n", int'(full_n0), 0);
      chk("full addr", int'(addr0), 1);
      push(8'h00); chk("overflow num", int'(num0), 3);
      chk("drain dout0", int'(dout0), 1);
      rd = 1'b1;
      tick(); chk("drain dout1", int'(dout0), 0);
      tick(); chk("drain dout2", int'(dout0), 1);
      tick(); chk("drain empty_n", int'(empty_n0), 0);
      rd = 1'b0;

      // full with simultaneous write and read: read wins, write refused
      push(8'h01); push(8'h00); push(8'h01);
      wr = 1'b1; rd = 1'b1; din = 8'h00;
      tick(); wr = 1'b0; rd = 1'b0;
      chk("fullrw num", int'(num0), 2);
      chk("fullrw full_n", int'(full_n0), 1);
      chk("fullrw dout", int'(dout0), 0);
      rd = 1'b1;
      tick(); chk("fullrw next", int'(dout0), 1);
      tick(); chk("fullrw empty", int'(empty_n0), 0);
      rd = 1'b0;

      // HEAD streaming: push+pop each cycle stays in the output register
      push(8'hA5);
      wr = 1'b1; rd = 1'b1;
      for (int i = 0; i < 10; i++) begin
         v = (i % 2 == 0) ? 8'h5A : 8'hC3;
         din = v; #1;
         chk("stream srl_we", int'(we0), 0);
         tick();
         chk("stream num", int'(num0), 1);
         chk("stream dout", int'(dout0), int'(v));
      end
      wr = 1'b0;
      tick(); rd = 1'b0;
      chk("stream empty", int'(empty_n0), 0);

      // reset mid-burst with a push in the reset cycle
      push(8'h11); push(8'h22);
      chk("prereset num", int'(num0), 2);
      wr = 1'b1; din = 8'h33; rst = 1'b1;
      tick(); rst = 1'b0; wr = 1'b0;
      chk("reset num", int'(num0), 0);
      chk("reset empty_n", int'(empty_n0), 0);
      chk("reset full_n", int'(full_n0), 1);
      chk("reset dout", int'(dout0), 0);
      chk("reset addr", int'(addr0), 0);

      // random traffic, phases biased toward filling then draining
      for (int i = 0; i < 1000; i++) begin
         int pw;
         pw  = ((i / 100) % 2 == 0) ? 3 : 1;
         wr  = ($urandom_range(0, 3) < pw);
         rd  = ($urandom_range(0, 3) >= pw);
         wce = ($urandom_range(0, 7) != 0);
         rce = ($urandom_range(0, 7) != 0);
         din = DW'($urandom_range(0, 255));
         tick();
      end
      wr = 1'b0; rd = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
